// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER pipeline: RV32I opcodes, load/store
// access types (funct3 encodings) and the memory-stage FSM states.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    // Access width/extension, straight from funct3 of the load/store.
    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

endpackage

// File: rtl/otter_mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
// The request fields stay stable from request until ack.
interface otter_mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);

endinterface

// File: rtl/otter_mem_align.sv
// Byte-lane formatting for the memory stage: store byte enables and lane
// replication, access-legality check, and load lane select with extension.
module otter_mem_align
    import otter_pkg::*;
(
    input  logic [2:0]  st_type,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_fmt,
    output logic        access_fault,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    // Store side: enables and replicated data from the access size.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        st_be        = 4'b1111;
        st_wdata_fmt = st_wdata;
        unique case (st_type[1:0])
            2'b00: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_wdata_fmt = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                st_be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata_fmt = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Misaligned halves/words and the unused funct3 codes are rejected.
    always_comb begin
        access_fault = 1'b1;
        case (st_type)
            MT_B, MT_BU: access_fault = 1'b0;
            MT_H, MT_HU: access_fault = st_addr_lo[0];
            MT_W:        access_fault = (st_addr_lo != 2'b00);
            default:     access_fault = 1'b1;
        endcase
    end

    // Load side: pick the lane, then sign- or zero-extend by type[2].
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        ld_byte = ld_rdata[7:0];
        unique case (ld_addr_lo)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            2'd3: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = ld_rdata;
        unique case (ld_type[1:0])
            2'b00:   ld_data = {{24{ld_byte[7] & ~ld_type[2]}}, ld_byte};
            2'b01:   ld_data = {{16{ld_half[15] & ~ld_type[2]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/otter_mem_stage.sv
// OTTER memory stage: accepts one instruction at a time from execute,
// performs at most one data-memory access, and pulses the result to
// write-back. Non-memory and faulting ops complete in one cycle.
module otter_mem_stage
    import otter_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [2:0]         ex_mem_type,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_wdata,
    input  logic [4:0]         ex_rd_addr,
    input  logic               ex_reg_write,
    otter_mem_stage_if.master  dmem,
    output logic               wb_valid,
    output logic [4:0]         wb_rd_addr,
    output logic               wb_reg_write,
    output logic [31:0]        wb_data,
    output logic               mem_fault
);

    mem_state_t  state;
    logic [2:0]  ld_type;
    logic [1:0]  ld_addr_lo;
    logic [4:0]  ld_rd_addr;
    logic        ld_reg_write;

    logic [3:0]  st_be;
    logic [31:0] st_wdata_fmt;
    logic        access_fault;
    logic [31:0] ld_data;
    logic        is_mem;

    assign ex_ready = (state == IDLE);
    assign is_mem   = ex_mem_read | ex_mem_write;

    otter_mem_align u_align (
        .st_type      (ex_mem_type),
        .st_addr_lo   (ex_addr[1:0]),
        .st_wdata     (ex_wdata),
        .st_be        (st_be),
        .st_wdata_fmt (st_wdata_fmt),
        .access_fault (access_fault),
        .ld_type      (ld_type),
        .ld_addr_lo   (ld_addr_lo),
        .ld_rdata     (dmem.rdata),
        .ld_data      (ld_data)
    );

    // Stage FSM: accept in IDLE, hold the bus request in REQ until ack.
    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: every register here, bus and write-back included, is
        // cleared by reset so an abandoned access leaves nothing behind.
        if (!RESET) begin
            state        <= IDLE;
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.be      <= '0;
            dmem.wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_rd_addr   <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            mem_fault    <= 1'b0;
            ld_type      <= '0;
            ld_addr_lo   <= '0;
            ld_rd_addr   <= '0;
            ld_reg_write <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values regardless of statement order.
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_addr;
                            wb_rd_addr   <= ex_rd_addr;
                            wb_reg_write <= ex_reg_write;
                        end else if (access_fault) begin
                            wb_valid     <= 1'b1;
                            mem_fault    <= 1'b1;
                            wb_rd_addr   <= ex_rd_addr;
                            wb_reg_write <= 1'b0;
                        end else begin
                            dmem.req     <= 1'b1;
                            dmem.we      <= ex_mem_write;
                            dmem.addr    <= {ex_addr[31:2], 2'b00};
                            dmem.be      <= st_be;
                            dmem.wdata   <= st_wdata_fmt;
                            ld_type      <= ex_mem_type;
                            ld_addr_lo   <= ex_addr[1:0];
                            ld_rd_addr   <= ex_rd_addr;
                            ld_reg_write <= ex_reg_write;
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem.ack) begin
                        dmem.req   <= 1'b0;
                        wb_valid   <= 1'b1;
                        wb_rd_addr <= ld_rd_addr;
                        if (dmem.we) begin
                            wb_reg_write <= 1'b0;
                        end else begin
                            wb_reg_write <= ld_reg_write;
                            wb_data      <= ld_data;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_stage.sv
// Directed testbench for otter_mem_stage: non-memory pass-through, stores,
// loads with extension, delayed ack, faults, and reset during an access.
module tb_otter_mem_stage;

    logic        CLK;
    logic        RESET;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_mem_type;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        mem_fault;

    int tests_run = 0;
    int tests_failed = 0;

    otter_mem_stage_if dmem_bus ();

    otter_mem_stage dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_mem_type  (ex_mem_type),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write),
        .dmem         (dmem_bus.master),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .mem_fault    (mem_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds the op for one rising edge.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rda, input logic rw);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_mem_type  = t;
        ex_addr      = a;
        ex_wdata     = wd;
        ex_rd_addr   = rda;
        ex_reg_write = rw;
        @(negedge CLK);
        ex_valid = 1'b0;
    endtask

    task automatic ack_one;
        dmem_bus.ack = 1'b1;
        @(negedge CLK);
        dmem_bus.ack = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] exp);
        issue(1'b1, 1'b0, t, a, 32'h0, 5'd9, 1'b1);
        check({tag, "_req"}, dmem_bus.req, 1);
        check({tag, "_we"}, dmem_bus.we, 0);
        check({tag, "_addr"}, dmem_bus.addr, a & 32'hFFFF_FFFC);
        ack_one();
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_data"}, wb_data, exp);
        check({tag, "_rw"}, wb_reg_write, 1);
        check({tag, "_rd"}, wb_rd_addr, 9);
    endtask

    initial begin
        RESET = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_mem_type = 3'b000; ex_addr = '0; ex_wdata = '0;
        ex_rd_addr = '0; ex_reg_write = 1'b0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_ready", ex_ready, 1);
        check("rst_req", dmem_bus.req, 0);
        check("rst_be", dmem_bus.be, 0);
        check("rst_addr", dmem_bus.addr, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_fault", mem_fault, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // Non-memory op passes ALU result straight through
        issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
        check("alu_wbv", wb_valid, 1);
        check("alu_data", wb_data, 32'h1234_5678);
        check("alu_rd", wb_rd_addr, 5);
        check("alu_rw", wb_reg_write, 1);
        check("alu_fault", mem_fault, 0);
        check("alu_req", dmem_bus.req, 0);
        @(negedge CLK);
        check("alu_pulse", wb_valid, 0);
        check("alu_hold", wb_data, 32'h1234_5678);

        // Ack while idle must do nothing
        ack_one();
        check("idle_ack_wbv", wb_valid, 0);
        check("idle_ack_ready", ex_ready, 1);

        // SW 0x100, ack in first REQ cycle
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd1, 1'b1);
        check("sw_req", dmem_bus.req, 1);
        check("sw_we", dmem_bus.we, 1);
        check("sw_addr", dmem_bus.addr, 32'h100);
        check("sw_be", dmem_bus.be, 4'b1111);
        check("sw_wdata", dmem_bus.wdata, 32'hDEAD_BEEF);
        check("sw_ready", ex_ready, 0);
        check("sw_wbv0", wb_valid, 0);
        ack_one();
        check("sw_wbv", wb_valid, 1);
        check("sw_rw", wb_reg_write, 0);
        check("sw_req_off", dmem_bus.req, 0);
        check("sw_ready1", ex_ready, 1);
        check("sw_wbdata_hold", wb_data, 32'h1234_5678);

        // SB 0x103
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd2, 1'b0);
        check("sb_be", dmem_bus.be, 4'b1000);
        check("sb_wdata", dmem_bus.wdata, 32'hA5A5_A5A5);
        check("sb_addr", dmem_bus.addr, 32'h100);
        ack_one();
        check("sb_wbv", wb_valid, 1);

        // SH 0x102
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 5'd2, 1'b0);
        check("sh_be", dmem_bus.be, 4'b1100);
        check("sh_wdata", dmem_bus.wdata, 32'hBEEF_BEEF);
        ack_one();

        // Loads from word 0x1280FF34
        dmem_bus.rdata = 32'h1280_FF34;
        do_load("lb102", 3'b000, 32'h102, 32'hFFFF_FF80);
        do_load("lbu102", 3'b100, 32'h102, 32'h0000_0080);
        do_load("lh102", 3'b001, 32'h102, 32'h0000_1280);
        do_load("lh100", 3'b001, 32'h100, 32'hFFFF_FF34);
        do_load("lhu100", 3'b101, 32'h100, 32'h0000_FF34);
        do_load("lw104", 3'b010, 32'h104, 32'h1280_FF34);

        // Delayed ack; a pending non-memory op must wait for IDLE
        dmem_bus.rdata = 32'hA1B2_C3D4;
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd7, 1'b1);
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_addr = 32'h0000_CAFE; ex_rd_addr = 5'd3; ex_reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dly_ready_%0d", i), ex_ready, 0);
            check($sformatf("dly_req_%0d", i), dmem_bus.req, 1);
            check($sformatf("dly_addr_%0d", i), dmem_bus.addr, 32'h200);
            check($sformatf("dly_be_%0d", i), dmem_bus.be, 4'b1111);
            check($sformatf("dly_wbv_%0d", i), wb_valid, 0);
            if (i == 3) dmem_bus.ack = 1'b1;
            @(negedge CLK);
        end
        dmem_bus.ack = 1'b0;
        check("dly_wbv", wb_valid, 1);
        check("dly_data", wb_data, 32'hA1B2_C3D4);
        check("dly_rd", wb_rd_addr, 7);
        check("dly_ready1", ex_ready, 1);
        @(negedge CLK);
        ex_valid = 1'b0;
        check("dly_next_wbv", wb_valid, 1);
        check("dly_next_data", wb_data, 32'h0000_CAFE);
        check("dly_next_rd", wb_rd_addr, 3);

        // Faults: misaligned word, misaligned half store, illegal type
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1);
        check("lw_mis_req", dmem_bus.req, 0);
        check("lw_mis_wbv", wb_valid, 1);
        check("lw_mis_fault", mem_fault, 1);
        check("lw_mis_rw", wb_reg_write, 0);
        check("lw_mis_ready", ex_ready, 1);
        @(negedge CLK);
        check("lw_mis_pulse", mem_fault, 0);
        issue(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 5'd0, 1'b0);
        check("sh_mis_fault", mem_fault, 1);
        check("sh_mis_req", dmem_bus.req, 0);
        issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 1'b1);
        check("ill_fault", mem_fault, 1);
        check("ill_req", dmem_bus.req, 0);
        @(negedge CLK);

        // Reset in the middle of a request
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd8, 1'b1);
        check("rr_req1", dmem_bus.req, 1);
        #2 RESET = 1'b0;
        #1;
        check("rr_req_async", dmem_bus.req, 0);
        check("rr_ready_async", ex_ready, 1);
        check("rr_addr", dmem_bus.addr, 0);
        @(negedge CLK);
        RESET = 1'b1;
        dmem_bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("rr_wbv_%0d", i), wb_valid, 0);
            check($sformatf("rr_ready_%0d", i), ex_ready, 1);
            check($sformatf("rr_reqoff_%0d", i), dmem_bus.req, 0);
        end
        dmem_bus.ack = 1'b0;
        check("rr_wbdata", wb_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/otter_mem_stage.md
OTTER_MEM_STAGE -- requirements
Module: otter_mem_stage

Interface
REQ-001 No parameters; all widths fixed as listed; one clock, reset is asynchronous and active-low.
REQ-002 CLK  in  1  sole clock, all state on rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  execute stage presents an instruction.
REQ-005 ex_ready  out  1  stage accepts; transfer on ex_valid & ex_ready at rising edge.
REQ-006 ex_mem_read  in  1  load.
REQ-007 ex_mem_write  in  1  store.
REQ-008 ex_mem_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 ex_addr  in  32  ALU result: byte address for memory ops, WB data otherwise.
REQ-010 ex_wdata  in  32  store data (rs2).
REQ-011 ex_rd_addr  in  5  destination register.
REQ-012 ex_reg_write  in  1  instruction writes rd.
REQ-013 dmem_req  out  1  bus request, registered.
REQ-014 dmem_we  out  1  1 store, 0 load.
REQ-015 dmem_addr  out  32  word-aligned address, {ex_addr[31:2],2'b00}.
REQ-016 dmem_be  out  4  byte enables.
REQ-017 dmem_wdata  out  32  lane-replicated store data.
REQ-018 dmem_ack  in  1  bus completes request this cycle.
REQ-019 dmem_rdata  in  32  read word, valid with dmem_ack.
REQ-020 wb_valid  out  1  one-cycle pulse: result to write-back.
REQ-021 wb_rd_addr  out  5  destination register.
REQ-022 wb_reg_write  out  1  register write enable for write-back.
REQ-023 wb_data  out  32  aligned/extended load data or passed ALU result.
REQ-024 mem_fault  out  1  misaligned or illegal-type access, pulses with wb_valid.

Function
REQ-025 FSM states IDLE, REQ; ex_ready = (state==IDLE).
REQ-026 IDLE, accepted non-memory op: next edge wb_valid=1, wb_data=ex_addr, wb_reg_write=ex_reg_write; stay IDLE.
REQ-027 IDLE, accepted aligned memory op: latch dmem_* fields, rd, reg_write, type, addr[1:0]; next state REQ; wb_valid stays 0.
REQ-028 Fault: H/HU/SH with addr[0]=1, W with addr[1:0]!=0, or type 011/110/111; no bus access; next edge wb_valid=1, mem_fault=1, wb_reg_write=0; stay IDLE.
REQ-029 REQ: dmem_req=1; dmem_we/addr/be/wdata held stable until dmem_ack sampled high.
REQ-030 REQ with dmem_ack: next edge dmem_req=0, wb_valid=1, state IDLE; load sets wb_reg_write=latched reg_write, store sets wb_reg_write=0.
REQ-031 Minimum latency: accept edge t, dmem_req high cycle t+1, ack in t+1 -> wb_valid in t+2, ex_ready=1 in t+2.
REQ-032 Store enables: B 4'b0001<<addr[1:0]; H 0011 (addr[1]=0) or 1100; W 1111; wdata B {4{byte}}, H {2{half}}, W unchanged.
REQ-033 Load: select byte lane addr[1:0] or half lane addr[1]; type[2]=0 sign-extends, 1 zero-extends.
REQ-034 dmem_ack outside REQ ignored; ex_* inputs ignored while ex_ready=0.
REQ-035 wb_valid and mem_fault are single-cycle; other wb_* outputs hold last value.

Reset
REQ-036 RESET low immediately forces state IDLE and dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write, mem_fault to 0; dmem_addr, dmem_wdata, wb_data, wb_rd_addr to 0.
REQ-037 Reset during REQ abandons the access; an ack arriving after release is ignored.

Structure
REQ-038 Shared package otter_pkg holds opcode_t, mem_type constants (MT_B, MT_H, MT_W, MT_BU, MT_HU) and the FSM state enum.
REQ-039 Combinational sub-module otter_mem_align performs byte-enable/wdata formatting and load lane select/extension.

Verification
REQ-040 SW addr 0x100, wdata 0xDEADBEEF, ack in first REQ cycle -> be 1111, dmem_addr 0x100, wdata 0xDEADBEEF, wb_valid at t+2, wb_reg_write 0.
REQ-041 SB addr 0x103, wdata 0x000000A5 -> be 1000, dmem_wdata 0xA5A5A5A5, dmem_addr 0x100.
REQ-042 rdata 0x1280FF34: LB 0x102 -> 0xFFFFFF80; LBU 0x102 -> 0x00000080; LH 0x102 -> 0x00001280; LH 0x100 -> 0xFFFFFF34.
REQ-043 Ack delayed 3 cycles -> dmem outputs stable, ex_ready 0 for 4 cycles, following op accepted only after return to IDLE.
REQ-044 LW addr 0x101 -> no dmem_req, wb_valid and mem_fault 1 next cycle, wb_reg_write 0.
REQ-045 RESET low mid-REQ -> dmem_req 0 asynchronously, wb_valid never pulses, ex_ready 1 after release, late ack ignored.
